count_sequencer: RTL and testbench

//   Controller for the free-running counter datapath: starts, stops, pauses and rate-limits it.

---
 rtl/count_sequencer.sv | 134 +++++++++++++
 tb/tb_count_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - start/stop/pause/rate-limit sequencer for an external free-running counter
// Compares against the counter value corrected for the strobe still in flight.

module count_sequencer #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd_op,
   input  logic [WIDTH-1:0] i_cmd_data,
   input  logic [WIDTH-1:0] i_cnt_q,
   output logic             o_cnt_clr,
   output logic             o_cnt_inc,
   output logic [1:0]       o_state,
   output logic             o_done,
   output logic [WIDTH-1:0] o_wraps
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_SET_LIMIT = 2'd0;
   localparam logic [1:0] OP_START     = 2'd1;
   localparam logic [1:0] OP_STOP      = 2'd2;
   localparam logic [1:0] OP_PAUSE     = 2'd3;

   state_t             r_state,    w_state_nx;
   logic [WIDTH-1:0]   r_limit,    w_limit_nx;
   logic [PRE_W-1:0]   r_prescale, w_prescale_nx;
   logic               r_periodic, w_periodic_nx;
   logic [PRE_W-1:0]   r_pre_cnt,  w_pre_nx;
   logic [WIDTH-1:0]   r_wraps,    w_wraps_nx;
   logic               r_cnt_clr,  w_clr_nx;
   logic               r_cnt_inc,  w_inc_nx;
   logic               r_done,     w_done_nx;

   logic               w_ready;
   logic               w_accept;
   logic               w_tick;
   logic [WIDTH-1:0]   w_cnt_eff;

   // Strobes issued last cycle land on the counter at the coming edge.
   assign w_cnt_eff = r_cnt_clr ? '0 : (r_cnt_inc ? i_cnt_q + WIDTH'(1) : i_cnt_q);
   assign w_tick    = (r_state == S_RUN) && (r_pre_cnt == r_prescale);
   assign w_ready   = !i_rst && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (i_cmd_op == OP_STOP) || (i_cmd_op == OP_PAUSE));
   assign w_accept  = i_cmd_valid && w_ready;

   always_comb begin
      w_state_nx    = r_state;
      w_limit_nx    = r_limit;
      w_prescale_nx = r_prescale;
      w_periodic_nx = r_periodic;
      w_pre_nx      = r_pre_cnt;
      w_wraps_nx    = r_wraps;
      w_clr_nx      = 1'b0;
      w_inc_nx      = 1'b0;
      w_done_nx     = 1'b0;
      if (w_accept) begin
         case (i_cmd_op)
            OP_SET_LIMIT: w_limit_nx = i_cmd_data;
            OP_START: begin
               w_periodic_nx = i_cmd_data[0];
               w_prescale_nx = i_cmd_data[PRE_W:1];
               w_pre_nx      = '0;
               w_clr_nx      = 1'b1;
               w_wraps_nx    = '0;
               w_state_nx    = S_RUN;
            end
            OP_STOP: w_state_nx = S_IDLE;
            default: begin
               if (r_state == S_RUN)
                  w_state_nx = S_PAUSE;
               else if (r_state == S_PAUSE)
                  w_state_nx = S_RUN;
            end
         endcase
      end else if (w_tick) begin
         w_pre_nx = '0;
         if (w_cnt_eff == r_limit) begin
            w_done_nx = 1'b1;
            if (r_periodic) begin
               w_clr_nx   = 1'b1;
               w_wraps_nx = r_wraps + WIDTH'(1);
            end else begin
               w_state_nx = S_DONE;
            end
         end else begin
            w_inc_nx = 1'b1;
         end
      end else if (r_state == S_RUN) begin
         w_pre_nx = r_pre_cnt + PRE_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_limit    <= '1;
         r_prescale <= '0;
         r_periodic <= 1'b0;
         r_pre_cnt  <= '0;
         r_wraps    <= '0;
         r_cnt_clr  <= 1'b1;
         r_cnt_inc  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_limit    <= w_limit_nx;
         r_prescale <= w_prescale_nx;
         r_periodic <= w_periodic_nx;
         r_pre_cnt  <= w_pre_nx;
         r_wraps    <= w_wraps_nx;
         r_cnt_clr  <= w_clr_nx;
         r_cnt_inc  <= w_inc_nx;
         r_done     <= w_done_nx;
      end
   end

   assign o_cmd_ready = w_ready;
   assign o_cnt_clr   = r_cnt_clr;
   assign o_cnt_inc   = r_cnt_inc;
   assign o_state     = r_state;
   assign o_done      = r_done;
   assign o_wraps     = r_wraps;

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer with a transaction-level model
// The model tracks the logical count directly; expected outputs are queued per cycle.

module tb_count_sequencer;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_cmd_valid = 1'b0;
   logic       o_cmd_ready;
   logic [1:0] i_cmd_op = 2'd0;
   logic [7:0] i_cmd_data = 8'd0;
   logic [7:0] cnt = 8'd0;
   logic       o_cnt_clr, o_cnt_inc, o_done;
   logic [1:0] o_state;
   logic [7:0] o_wraps;

   always #5 clk = ~clk;

   count_sequencer #(.WIDTH(8), .PRE_W(4)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data), .i_cnt_q(cnt),
      .o_cnt_clr(o_cnt_clr), .o_cnt_inc(o_cnt_inc), .o_state(o_state),
      .o_done(o_done), .o_wraps(o_wraps)
   );

   // Counter datapath being sequenced
   always @(posedge clk) begin
      if (o_cnt_clr)      cnt <= 8'd0;
      else if (o_cnt_inc) cnt <= cnt + 8'd1;
   end

   typedef struct {
      int         st;
      logic       clr, inc, done;
      logic [7:0] wraps;
      logic [7:0] count;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   // Model state: 0 idle, 1 run, 2 pause, 3 done
   int         m_state;
   logic [7:0] m_limit, m_wraps, m_count;
   int         m_prescale, m_phase;
   logic       m_periodic;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic [1:0] op, input logic [7:0] d);
      exp_t e;
      logic exp_ready, acc;
      @(negedge clk);
      i_rst = rst; i_cmd_valid = v; i_cmd_op = op; i_cmd_data = d;
      #1;
      exp_ready = !rst && (m_state == 0 || m_state == 3 || op == 2'd2 || op == 2'd3);
      check("cmd_ready", int'(o_cmd_ready), int'(exp_ready));
      acc = v && exp_ready;
      e.clr = 1'b0; e.inc = 1'b0; e.done = 1'b0;
      if (rst) begin
         m_state = 0; m_limit = 8'hFF; m_prescale = 0; m_periodic = 1'b0;
         m_phase = 0; m_wraps = 8'd0; m_count = 8'd0; e.clr = 1'b1;
      end else if (acc) begin
         if (op == 2'd0) m_limit = d;
         else if (op == 2'd1) begin
            m_periodic = d[0]; m_prescale = int'(d[4:1]); m_phase = 0;
            m_count = 8'd0; m_wraps = 8'd0; e.clr = 1'b1; m_state = 1;
         end else if (op == 2'd2) m_state = 0;
         else if (m_state == 1) m_state = 2;
         else if (m_state == 2) m_state = 1;
      end else if (m_state == 1) begin
         if (m_phase == m_prescale) begin
            m_phase = 0;
            if (m_count == m_limit) begin
               e.done = 1'b1;
               if (m_periodic) begin
                  e.clr = 1'b1; m_count = 8'd0; m_wraps = m_wraps + 8'd1;
               end else m_state = 3;
            end else begin
               e.inc = 1'b1; m_count = m_count + 8'd1;
            end
         end else m_phase++;
      end
      e.st = m_state; e.wraps = m_wraps; e.count = m_count;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 8'd0);
   endtask

   // Monitor: every clock the DUT presents a fresh set of registered outputs
   initial begin
      exp_t e;
      logic [7:0] prev_count;
      bit prev_valid = 0;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state", int'(o_state), e.st);
            check("cnt_clr", int'(o_cnt_clr), int'(e.clr));
            check("cnt_inc", int'(o_cnt_inc), int'(e.inc));
            check("done", int'(o_done), int'(e.done));
            check("wraps", int'(o_wraps), int'(e.wraps));
            if (prev_valid) check("cnt_q", int'(cnt), int'(prev_count));
            prev_count = e.count;
            prev_valid = 1;
         end
      end
   end

   initial begin
      // reset then one-shot to limit 5
      step(1'b1, 1'b0, 2'd0, 8'd0);
      step(1'b1, 1'b0, 2'd0, 8'd0);
      step(1'b0, 1'b1, 2'd0, 8'd5);
      step(1'b0, 1'b1, 2'd1, 8'd0);
      idle(10);
      // periodic, limit 3, prescale 2
      step(1'b0, 1'b1, 2'd0, 8'd3);
      step(1'b0, 1'b1, 2'd1, 8'd5);
      idle(28);
      // pause / resume
      step(1'b0, 1'b1, 2'd3, 8'd0);
      idle(10);
      step(1'b0, 1'b1, 2'd3, 8'd0);
      idle(12);
      // SET_LIMIT refused while running, then STOP
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd0, 8'd9);
      step(1'b0, 1'b1, 2'd2, 8'd0);
      // STOP coinciding with the terminal tick
      step(1'b0, 1'b1, 2'd0, 8'd2);
      step(1'b0, 1'b1, 2'd1, 8'd0);
      idle(2);
      step(1'b0, 1'b1, 2'd2, 8'd0);
      idle(3);
      // limit 0 periodic, then reset mid-run
      step(1'b0, 1'b1, 2'd0, 8'd0);
      step(1'b0, 1'b1, 2'd1, 8'd1);
      idle(5);
      step(1'b0, 1'b1, 2'd0, 8'd8);
      step(1'b0, 1'b1, 2'd2, 8'd0);
      step(1'b0, 1'b1, 2'd0, 8'd8);
      step(1'b0, 1'b1, 2'd1, 8'd1);
      idle(6);
      step(1'b1, 1'b1, 2'd1, 8'd0);
      idle(4);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic       r, v;
         logic [1:0] op;
         logic [7:0] d;
         r  = ($urandom % 300) == 0;
         v  = ($urandom % 5) == 0;
         op = 2'($urandom % 4);
         d  = (op == 2'd0) ? 8'($urandom % 8) : 8'($urandom);
         step(r, v, op, d);
      end
      i_cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
